axi4_rrch_sender_burst: RTL and testbench
=========================================

Name: axi4_rrch_sender_burst

Overview:
Successor to the single-beat read-response drop injector. It sits on the AXI4 R channel between the downstream slave (m_ side) and the upstream master (s_ side). It passes slave read data through unchanged. For each dropped read transaction queued on the trans_* interface, it synthesises a full error burst of trans_len+1 beats with a per-transaction response code. Generalisations over the previous block: burst-aware injection, a configurable-depth drop queue with backpressure, burst-boundary-safe arbitration, and round-robin fairness.

Parameters:
C_AXI_DATA_WIDTH, 32, R data width
C_AXI_ID_WIDTH, 4, R ID width
C_AXI_USER_WIDTH, 4, R user width
C_DROP_FIFO_DEPTH, 4, drop-queue entries; power of 2, minimum 2

Ports:
axi4_aclk  in  1  clock
axi4_arstn  in  1  asynchronous active-low reset
trans_id  in  C_AXI_ID_WIDTH  ID of dropped transaction
trans_len  in  8  AXI ARLEN of dropped transaction (beats-1)
trans_resp  in  2  response code to inject (2'b10 SLVERR, 2'b11 DECERR)
trans_drop  in  1  push request (valid)
trans_ready  out  1  queue not full
s_axi4_rid / rdata / rresp / rlast / ruser / rvalid  out  per widths  R channel to master
s_axi4_rready  in  1
m_axi4_rid / rdata / rresp / rlast / ruser / rvalid  in  per widths  R channel from slave
m_axi4_rready  out  1

Behaviour:
- One clock: axi4_aclk. Reset is asynchronous and active-low on axi4_arstn.
- Reset state: state=IDLE, queue empty, beat_cnt=0, last_was_master=0.
- Outputs after reset: trans_ready=1; s_* mirror m_* (pass-through), so s_axi4_rvalid=m_axi4_rvalid and m_axi4_rready=s_axi4_rready.
- Queue:
  - Push {id,len,resp} when trans_drop && trans_ready.
  - trans_ready is registered !full. A pop in the same cycle does not free a slot for a push while full.
  - Upstream holds trans_* while trans_ready=0.
  - Push and pop in the same cycle with the queue non-full are both performed.
- States: IDLE, PASS, DROP.
- Combinational grant in IDLE: drop_sel = q_valid && (!m_axi4_rvalid || last_was_master).
- IDLE, drop_sel=1: present injected beat 0, m_axi4_rready=0.
  - Accepted and len==0: pop, last_was_master=0, stay IDLE.
  - Accepted and len>0: beat_cnt=1, go to DROP.
  - Not accepted: go to DROP with beat_cnt=0. The grant is locked to keep the beat stable per AXI.
- IDLE, drop_sel=0: pass-through.
  - Master beat accepted with rlast=1: last_was_master=1, stay IDLE.
  - Master beat accepted with rlast=0, or m_axi4_rvalid=1 but not accepted: go to PASS.
- PASS: pure pass-through; injection is never allowed mid-burst. On an accepted beat with m_axi4_rlast=1: last_was_master=1, go to IDLE.
- DROP outputs:
  - s_axi4_rvalid=1, m_axi4_rready=0.
  - rid=q.id, rresp=q.resp, rdata=0, ruser=0.
  - rlast=(beat_cnt==q.len).
- DROP transitions: each accepted beat increments beat_cnt. On the accepted last beat: pop, beat_cnt=0, last_was_master=0, go to IDLE.
- Fairness: queued drops and slave bursts alternate at burst boundaries. Neither side can starve the other.
- beat_cnt is 8 bits; len=255 yields 256 beats with no wrap.
- Slave R-channel signals are not modified in PASS, including rresp.
- Reset mid-burst aborts the burst immediately; queue contents are lost. The system must reset both sides together.

Decomposition:
- Package axi4_rab_pkg:
  - RESP_OKAY / RESP_SLVERR / RESP_DECERR constants
  - rrch_state_t enum {IDLE, PASS, DROP}
  - drop entry struct {id, len, resp}
- Sub-module axi4_drop_fifo: parametrised sync FIFO (DATA_WIDTH, DEPTH) with valid/ready on both sides, registered full, async active-low reset.

Test Plan:
- Single-beat drop, slave idle: push id=3, len=0, resp=2'b10 -> next cycle one beat rid=3, rresp=10, rlast=1, rdata=0; trans_ready stays 1.
- Burst drop with backpressure: push id=5, len=3, resp=2'b11; s_axi4_rready toggles 1,0,1,1,0,1 -> exactly 4 beats rresp=11; rlast only on 4th; outputs stable while rready=0; m_axi4_rready=0 throughout.
- Mid-burst protection: slave sends 4-beat burst id=1; push a drop after beat 1 -> all 4 slave beats delivered contiguously, then the drop burst.
- Fairness: slave streams back-to-back single-beat bursts while 2 drops are queued -> order master, drop, master, drop, master.
- Queue full: DEPTH=4, hold s_axi4_rready=0, push 5 -> trans_ready=0 after the 4th push; 5th held; after the first drop completes, the 5th is accepted and all 5 emerge in order with correct IDs.
- Reset mid-DROP at beat 2 of len=7 -> s_axi4_rvalid follows m_axi4_rvalid in the next cycle, trans_ready=1, no stale beats afterwards.

Source files
------------

// File: rtl/axi4_rab_pkg.sv
// Shared types for the AXI4 R-channel drop/inject blocks.
// The drop queue carries one entry per dropped read transaction.
package axi4_rab_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    localparam int LEN_W  = 8;
    localparam int RESP_W = 2;

    typedef enum logic [1:0] {
        IDLE,
        PASS,
        DROP
    } rrch_state_t;

    // ID width is a per-instance parameter, so the top pairs this
    // with its own ID field to form the full queue entry.
    typedef struct packed {
        logic [LEN_W-1:0]  len;
        logic [RESP_W-1:0] resp;
    } drop_ctl_t;

    localparam int DROP_CTL_W = $bits(drop_ctl_t);

    function automatic logic is_err_resp(input logic [1:0] r);
        return (r == RESP_SLVERR) || (r == RESP_DECERR);
    endfunction

endpackage

// File: rtl/axi4_drop_fifo.sv
// Synchronous valid/ready FIFO holding pending drop entries.
// in_ready_o is a registered !full, so a same-cycle pop never admits a push.
module axi4_drop_fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  in_valid_i,
    input  logic [DATA_WIDTH-1:0] in_data_i,
    output logic                  in_ready_o,
    output logic                  out_valid_o,
    output logic [DATA_WIDTH-1:0] out_data_o,
    input  logic                  out_ready_i
);

    localparam int AW = $clog2(DEPTH);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [AW:0]           cnt_q, cnt_d;
    logic                  full_q, full_d;
    logic                  push, pop;

    assign in_ready_o  = !full_q;
    assign out_valid_o = (cnt_q != '0);
    assign out_data_o  = mem_q[rd_ptr_q];

    assign push = in_valid_i && !full_q;
    assign pop  = out_valid_o && out_ready_i;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        if (push && !pop) begin
            cnt_d = cnt_q + 1'b1;
        end else if (!push && pop) begin
            cnt_d = cnt_q - 1'b1;
        end
        full_d = (cnt_d == (AW+1)'(DEPTH));
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            full_q   <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            full_q   <= full_d;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (push) begin
            mem_q[wr_ptr_q] <= in_data_i;
        end
    end

endmodule

// File: rtl/axi4_rrch_sender_burst.sv
// AXI4 R-channel pass-through that injects full error bursts for
// dropped reads, alternating with slave bursts at burst boundaries.
module axi4_rrch_sender_burst
    import axi4_rab_pkg::*;
#(
    parameter int C_AXI_DATA_WIDTH  = 32,
    parameter int C_AXI_ID_WIDTH    = 4,
    parameter int C_AXI_USER_WIDTH  = 4,
    parameter int C_DROP_FIFO_DEPTH = 4
) (
    input  logic                        axi4_aclk,
    input  logic                        axi4_arstn,
    input  logic [C_AXI_ID_WIDTH-1:0]   trans_id,
    input  logic [7:0]                  trans_len,
    input  logic [1:0]                  trans_resp,
    input  logic                        trans_drop,
    output logic                        trans_ready,
    output logic [C_AXI_ID_WIDTH-1:0]   s_axi4_rid,
    output logic [C_AXI_DATA_WIDTH-1:0] s_axi4_rdata,
    output logic [1:0]                  s_axi4_rresp,
    output logic                        s_axi4_rlast,
    output logic [C_AXI_USER_WIDTH-1:0] s_axi4_ruser,
    output logic                        s_axi4_rvalid,
    input  logic                        s_axi4_rready,
    input  logic [C_AXI_ID_WIDTH-1:0]   m_axi4_rid,
    input  logic [C_AXI_DATA_WIDTH-1:0] m_axi4_rdata,
    input  logic [1:0]                  m_axi4_rresp,
    input  logic                        m_axi4_rlast,
    input  logic [C_AXI_USER_WIDTH-1:0] m_axi4_ruser,
    input  logic                        m_axi4_rvalid,
    output logic                        m_axi4_rready
);

    typedef struct packed {
        logic [C_AXI_ID_WIDTH-1:0] id;
        drop_ctl_t                 ctl;
    } drop_entry_t;

    localparam int ENTRY_W = $bits(drop_entry_t);

    rrch_state_t state_q, state_d;
    logic [7:0]  beat_cnt_q, beat_cnt_d;
    logic        last_was_master_q, last_was_master_d;

    drop_entry_t push_e, q_e;
    logic        q_valid;
    logic        q_pop;
    logic        drop_sel;
    logic        inject;
    logic        is_last;

    always_comb begin
        push_e          = '0;
        push_e.id       = trans_id;
        push_e.ctl.len  = trans_len;
        push_e.ctl.resp = trans_resp;
    end

    axi4_drop_fifo #(
        .DATA_WIDTH (ENTRY_W),
        .DEPTH      (C_DROP_FIFO_DEPTH)
    ) u_drop_fifo (
        .clk_i       (axi4_aclk),
        .rst_ni      (axi4_arstn),
        .in_valid_i  (trans_drop),
        .in_data_i   (push_e),
        .in_ready_o  (trans_ready),
        .out_valid_o (q_valid),
        .out_data_o  (q_e),
        .out_ready_i (q_pop)
    );

    assign drop_sel = q_valid && (!m_axi4_rvalid || last_was_master_q);
    assign is_last  = (beat_cnt_q == q_e.ctl.len);

    always_comb begin
        state_d           = state_q;
        beat_cnt_d        = beat_cnt_q;
        last_was_master_d = last_was_master_q;
        q_pop             = 1'b0;
        inject            = 1'b0;

        s_axi4_rid    = m_axi4_rid;
        s_axi4_rdata  = m_axi4_rdata;
        s_axi4_rresp  = m_axi4_rresp;
        s_axi4_rlast  = m_axi4_rlast;
        s_axi4_ruser  = m_axi4_ruser;
        s_axi4_rvalid = m_axi4_rvalid;
        m_axi4_rready = s_axi4_rready;

        unique case (state_q)
            IDLE: begin
                if (drop_sel) begin
                    inject = 1'b1;
                    // An unaccepted beat locks the grant so it stays stable.
                    if (!s_axi4_rready) begin
                        state_d = DROP;
                    end else if (is_last) begin
                        q_pop             = 1'b1;
                        last_was_master_d = 1'b0;
                    end else begin
                        beat_cnt_d = beat_cnt_q + 8'd1;
                        state_d    = DROP;
                    end
                end else if (m_axi4_rvalid) begin
                    if (s_axi4_rready && m_axi4_rlast) begin
                        last_was_master_d = 1'b1;
                    end else begin
                        state_d = PASS;
                    end
                end
            end
            PASS: begin
                if (m_axi4_rvalid && s_axi4_rready && m_axi4_rlast) begin
                    last_was_master_d = 1'b1;
                    state_d           = IDLE;
                end
            end
            DROP: begin
                inject = 1'b1;
                if (s_axi4_rready) begin
                    if (is_last) begin
                        q_pop             = 1'b1;
                        beat_cnt_d        = 8'd0;
                        last_was_master_d = 1'b0;
                        state_d           = IDLE;
                    end else begin
                        beat_cnt_d = beat_cnt_q + 8'd1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (inject) begin
            s_axi4_rid    = q_e.id;
            s_axi4_rdata  = '0;
            s_axi4_rresp  = q_e.ctl.resp;
            s_axi4_rlast  = is_last;
            s_axi4_ruser  = '0;
            s_axi4_rvalid = 1'b1;
            m_axi4_rready = 1'b0;
        end
    end

    always_ff @(posedge axi4_aclk or negedge axi4_arstn) begin
        if (!axi4_arstn) begin
            state_q           <= IDLE;
            beat_cnt_q        <= 8'd0;
            last_was_master_q <= 1'b0;
        end else begin
            state_q           <= state_d;
            beat_cnt_q        <= beat_cnt_d;
            last_was_master_q <= last_was_master_d;
        end
    end

endmodule

// File: tb/tb_axi4_rrch_sender_burst.sv
// Randomized bench for axi4_rrch_sender_burst against a burst-level
// scoreboard of queued drops and slave bursts.
module tb_axi4_rrch_sender_burst;

    localparam int DW    = 32;
    localparam int IW    = 4;
    localparam int UW    = 4;
    localparam int DEPTH = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [IW-1:0] trans_id;
    logic [7:0]    trans_len;
    logic [1:0]    trans_resp;
    logic          trans_drop;
    logic          trans_ready;
    logic [IW-1:0] s_rid, m_rid;
    logic [DW-1:0] s_rdata, m_rdata;
    logic [1:0]    s_rresp, m_rresp;
    logic          s_rlast, m_rlast;
    logic [UW-1:0] s_ruser, m_ruser;
    logic          s_rvalid, m_rvalid;
    logic          s_rready, m_rready;

    axi4_rrch_sender_burst #(
        .C_AXI_DATA_WIDTH  (DW),
        .C_AXI_ID_WIDTH    (IW),
        .C_AXI_USER_WIDTH  (UW),
        .C_DROP_FIFO_DEPTH (DEPTH)
    ) dut (
        .axi4_aclk     (clk),
        .axi4_arstn    (rst_n),
        .trans_id      (trans_id),
        .trans_len     (trans_len),
        .trans_resp    (trans_resp),
        .trans_drop    (trans_drop),
        .trans_ready   (trans_ready),
        .s_axi4_rid    (s_rid),
        .s_axi4_rdata  (s_rdata),
        .s_axi4_rresp  (s_rresp),
        .s_axi4_rlast  (s_rlast),
        .s_axi4_ruser  (s_ruser),
        .s_axi4_rvalid (s_rvalid),
        .s_axi4_rready (s_rready),
        .m_axi4_rid    (m_rid),
        .m_axi4_rdata  (m_rdata),
        .m_axi4_rresp  (m_rresp),
        .m_axi4_rlast  (m_rlast),
        .m_axi4_ruser  (m_ruser),
        .m_axi4_rvalid (m_rvalid),
        .m_axi4_rready (m_rready)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [IW-1:0] id;
        logic [7:0]    len;
        logic [1:0]    resp;
    } dent_t;

    int n_cmp = 0;
    int n_err = 0;

    // reference: pending drops in push order, burst lock, fairness flag
    dent_t dq[$];
    bit    bnd = 1'b1;
    bit    sdrop = 1'b0;
    bit    lwm = 1'b0;
    int    beat = 0;
    int    drops_done = 0;
    bit    hs_m = 1'b0;
    bit    hs_t = 1'b0;
    bit    prev_hold = 1'b0;
    logic [IW+2+1+DW-1:0] prev_beat;

    // stimulus knobs and driver state
    int p_rdy = 70;
    int p_m   = 50;
    int p_d   = 30;
    bit big_once = 1'b0;
    bit m_act = 1'b0;
    int m_len = 0;
    int m_beat = 0;
    bit d_act = 1'b0;

    task automatic chk(input string tag,
                       input logic [63:0] obs,
                       input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h @%0t",
                     tag, obs, exp, $time);
        end
    endtask

    task automatic m_present();
        m_rvalid = 1'b1;
        m_rdata  = $urandom;
        m_rresp  = 2'($urandom_range(0, 3));
        m_ruser  = UW'($urandom);
        m_rlast  = (m_beat == m_len);
    endtask

    task automatic drive();
        s_rready = ($urandom_range(0, 99) < p_rdy);
        if (hs_t) begin
            d_act      = 1'b0;
            trans_drop = 1'b0;
        end
        if (!d_act && $urandom_range(0, 99) < p_d) begin
            d_act      = 1'b1;
            trans_drop = 1'b1;
            trans_id   = IW'($urandom);
            trans_len  = big_once ? 8'd255 : 8'($urandom_range(0, 5));
            trans_resp = $urandom_range(0, 1) ? 2'b10 : 2'b11;
            big_once   = 1'b0;
        end
        if (hs_m) begin
            if (m_rlast) m_act = 1'b0;
            else m_beat++;
            m_rvalid = 1'b0;
        end
        if (m_act && !m_rvalid && $urandom_range(0, 99) < 80) begin
            m_present();
        end else if (!m_act && $urandom_range(0, 99) < p_m) begin
            m_act  = 1'b1;
            m_rid  = IW'($urandom);
            m_len  = $urandom_range(0, 3);
            m_beat = 0;
            m_present();
        end
        hs_m = 1'b0;
        hs_t = 1'b0;
    endtask

    task automatic check_cycle();
        bit wd;
        bit xd;
        if (bnd) begin
            wd = (dq.size() != 0) && (!m_rvalid || lwm);
            if (wd || m_rvalid) begin
                bnd   = 1'b0;
                sdrop = wd;
            end
        end
        xd = !bnd && sdrop;
        chk("trans_ready", trans_ready, dq.size() < DEPTH);
        if (prev_hold) begin
            chk("hold_valid", s_rvalid, 1);
            chk("hold_beat", {s_rid, s_rresp, s_rlast, s_rdata}, prev_beat);
        end
        if (xd) begin
            chk("inj_valid", s_rvalid, 1);
            chk("inj_id", s_rid, dq[0].id);
            chk("inj_resp", s_rresp, dq[0].resp);
            chk("inj_last", s_rlast, beat == int'(dq[0].len));
            chk("inj_data", {s_ruser, s_rdata}, 0);
            chk("inj_mready", m_rready, 0);
        end else begin
            chk("pt_valid", s_rvalid, m_rvalid);
            if (m_rvalid) begin
                chk("pt_beat", {s_rid, s_rdata, s_rresp, s_rlast, s_ruser},
                    {m_rid, m_rdata, m_rresp, m_rlast, m_ruser});
            end
            chk("pt_mready", m_rready, s_rready);
        end
        prev_hold = s_rvalid && !s_rready;
        prev_beat = {s_rid, s_rresp, s_rlast, s_rdata};
        hs_t = trans_drop && (dq.size() < DEPTH);
        if (xd && s_rready) begin
            if (beat == int'(dq[0].len)) begin
                void'(dq.pop_front());
                beat = 0;
                lwm  = 1'b0;
                bnd  = 1'b1;
                drops_done++;
            end else begin
                beat++;
            end
        end else if (!xd && m_rvalid && s_rready) begin
            hs_m = 1'b1;
            if (m_rlast) begin
                lwm = 1'b1;
                bnd = 1'b1;
            end
        end
        if (hs_t) begin
            dq.push_back('{id: trans_id, len: trans_len, resp: trans_resp});
        end
    endtask

    task automatic run_cycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1 drive();
            @(negedge clk);
            check_cycle();
        end
    endtask

    task automatic reset_mid_drop();
        bit done;
        p_m  = 0;
        p_d  = 0;
        p_rdy = 100;
        done = 1'b0;
        for (int i = 0; i < 3000 && !done; i++) begin
            run_cycles(1);
            done = bnd && dq.size() == 0 && !d_act && !m_act && !m_rvalid;
        end
        chk("drain_timeout", done, 1);
        @(posedge clk);
        #1;
        d_act      = 1'b1;
        trans_drop = 1'b1;
        trans_id   = 4'd6;
        trans_len  = 8'd7;
        trans_resp = 2'b11;
        @(negedge clk);
        check_cycle();
        done = 1'b0;
        for (int i = 0; i < 100 && !done; i++) begin
            run_cycles(1);
            done = !bnd && sdrop && beat == 2;
        end
        chk("reach_beat2", done, 1);
        #2 rst_n = 1'b0;
        dq.delete();
        bnd = 1'b1; sdrop = 1'b0; lwm = 1'b0; beat = 0;
        prev_hold = 1'b0; hs_m = 1'b0; hs_t = 1'b0;
        trans_drop = 1'b0; d_act = 1'b0; s_rready = 1'b0;
        m_act = 1'b1; m_len = 0; m_beat = 0; m_rid = 4'd9;
        m_present();
        #1;
        chk("rst_svalid", s_rvalid, m_rvalid);
        chk("rst_tready", trans_ready, 1);
        @(negedge clk);
        check_cycle();
        #2 rst_n = 1'b1;
    endtask

    initial begin
        rst_n      = 1'b0;
        trans_id   = '0;
        trans_len  = '0;
        trans_resp = 2'b10;
        trans_drop = 1'b0;
        s_rready   = 1'b1;
        m_rid      = 4'd2;
        m_rdata    = 32'hA5A5_0001;
        m_rresp    = 2'b01;
        m_rlast    = 1'b1;
        m_ruser    = 4'h3;
        m_rvalid   = 1'b1;
        #12;
        chk("rst_tready", trans_ready, 1);
        chk("rst_pt_valid", s_rvalid, m_rvalid);
        chk("rst_pt_mready", m_rready, s_rready);
        chk("rst_pt_data", s_rdata, m_rdata);
        m_rvalid = 1'b0;
        s_rready = 1'b0;
        #1;
        chk("rst_pt_novalid", s_rvalid, m_rvalid);
        @(negedge clk);
        rst_n = 1'b1;

        p_rdy = 70; p_m = 50; p_d = 30;
        run_cycles(4000);
        p_rdy = 15; p_m = 40; p_d = 90;
        run_cycles(3000);
        p_rdy = 60; p_m = 50; p_d = 20; big_once = 1'b1;
        run_cycles(1500);
        p_rdy = 90; p_m = 90; p_d = 50;
        run_cycles(1500);
        reset_mid_drop();
        p_rdy = 70; p_m = 50; p_d = 30;
        run_cycles(1500);
        chk("drops_seen", drops_done > 50, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
